thread_control_unit: RTL and testbench

- Memory-mapped controller that owns the per-thread enable mask for all cores. It replaces the ad hoc resume/halt logic at the processor top level.
- Decodes resume/halt/status writes and reads from the non-cacheable IO bus.
- Wakes a programmable set of threads on an external interrupt edge and, optionally, on expiry of a countdown timer.
- Drives processor_halt and exposes an interrupt-pending status register.

---
 rtl/thread_control_unit.sv | 120 ++++++++++++
 tb/tb_thread_control_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_control_unit.sv
// Memory-mapped owner of the per-thread enable mask: resume/halt/target/pending
// registers, interrupt wake, optional countdown wake (THREAD_CONTROL_WAKE_TIMER_EN).
module thread_control_unit #(
  parameter int          TOTAL_THREADS = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_write_en,
  input  logic                     io_read_en,
  input  logic [31:0]              io_address,
  input  logic [31:0]              io_write_data,
  output logic [31:0]              io_read_data,
  input  logic                     interrupt_req,
  output logic [TOTAL_THREADS-1:0] thread_enable,
  output logic                     processor_halt,
  output logic [1:0]               interrupt_pending
);

  typedef logic [TOTAL_THREADS-1:0] mask_t;

  localparam mask_t       THREAD0   = mask_t'(1);
  localparam logic [31:0] A_RESUME  = BASE_ADDR;
  localparam logic [31:0] A_HALT    = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_ENABLE  = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_TARGET  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_PENDING = BASE_ADDR + 32'h10;

  logic  sel_resume, sel_halt, sel_enable, sel_target, sel_pending;
  mask_t wdata_mask;
  mask_t enable_q, target_q;
  mask_t resume_bits, halt_bits, wake_mask, enable_d;
  logic [1:0]  pending_q, pending_d, ack_bits;
  logic [31:0] read_value;
  logic  sync1, sync2, sync_prev;
  logic  ext_wake, timer_wake;
  logic  unused_wdata;

  assign sel_resume  = (io_address == A_RESUME);
  assign sel_halt    = (io_address == A_HALT);
  assign sel_enable  = (io_address == A_ENABLE);
  assign sel_target  = (io_address == A_TARGET);
  assign sel_pending = (io_address == A_PENDING);
  assign wdata_mask  = io_write_data[TOTAL_THREADS-1:0];
  assign unused_wdata = ^io_write_data;

  // One-cycle pulse on the rising edge of the synchronized request.
  assign ext_wake = sync2 & ~sync_prev;

`ifdef THREAD_CONTROL_WAKE_TIMER_EN
  localparam logic [31:0] A_TIMER = BASE_ADDR + 32'h14;
  logic        sel_timer;
  logic [31:0] timer_q;

  assign sel_timer = (io_address == A_TIMER);
  // A write landing on the expiry cycle reloads and suppresses the wake.
  assign timer_wake = (timer_q == 32'd1) && !(io_write_en && sel_timer);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (io_write_en && sel_timer) begin
      timer_q <= io_write_data;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - 32'd1;
    end
  end
`else
  assign timer_wake = 1'b0;
`endif

  always_comb begin
    resume_bits = (io_write_en && sel_resume)  ? wdata_mask : '0;
    halt_bits   = (io_write_en && sel_halt)    ? wdata_mask : '0;
    ack_bits    = (io_write_en && sel_pending) ? io_write_data[1:0] : 2'b00;
    wake_mask   = (ext_wake || timer_wake) ? target_q : '0;
    enable_d    = ((enable_q | resume_bits) & ~halt_bits) | wake_mask;
    pending_d   = (pending_q & ~ack_bits) | {timer_wake, ext_wake};
  end

  always_comb begin
    read_value = '0;
    if (sel_enable) begin
      read_value[TOTAL_THREADS-1:0] = enable_q;
    end else if (sel_target) begin
      read_value[TOTAL_THREADS-1:0] = target_q;
    end else if (sel_pending) begin
      read_value[1:0] = pending_q;
`ifdef THREAD_CONTROL_WAKE_TIMER_EN
    end else if (sel_timer) begin
      read_value = timer_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q     <= THREAD0;
      target_q     <= THREAD0;
      pending_q    <= '0;
      io_read_data <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync_prev    <= 1'b0;
    end else begin
      sync1     <= interrupt_req;
      sync2     <= sync1;
      sync_prev <= sync2;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      if (io_write_en && sel_target) target_q <= wdata_mask;
      if (io_read_en) io_read_data <= read_value;
    end
  end

  assign thread_enable     = enable_q;
  assign processor_halt    = (enable_q == '0);
  assign interrupt_pending = pending_q;

endmodule

// File: tb/tb_thread_control_unit.sv
// Self-checking bench for thread_control_unit: directed scenarios plus random
// IO/interrupt traffic compared against a register-level reference model.
module tb_thread_control_unit;
  localparam int          T    = 4;
  localparam logic [31:0] BASE = 32'h60;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         io_write_en = 1'b0;
  logic         io_read_en = 1'b0;
  logic [31:0]  io_address = '0;
  logic [31:0]  io_write_data = '0;
  logic [31:0]  io_read_data;
  logic         interrupt_req = 1'b0;
  logic [T-1:0] thread_enable;
  logic         processor_halt;
  logic [1:0]   interrupt_pending;

  int checks = 0;
  int errors = 0;

  thread_control_unit #(.TOTAL_THREADS(T), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_address(io_address), .io_write_data(io_write_data), .io_read_data(io_read_data),
    .interrupt_req(interrupt_req), .thread_enable(thread_enable),
    .processor_halt(processor_halt), .interrupt_pending(interrupt_pending)
  );

  always #5 clk = ~clk;

  // Reference model: register values and the recent history of sampled requests.
  logic [T-1:0] m_en, m_tgt;
  logic [1:0]   m_pend;
  logic [31:0]  m_rd, m_timer;
  logic [2:0]   m_hist;  // bit0 = latest sample, bit2 = oldest

  function automatic logic hit(logic [31:0] off);
    return io_address == BASE + off;
  endfunction

  function automatic logic wr(logic [31:0] off);
    return io_write_en && hit(off);
  endfunction

  function automatic logic ext_wake();
    return m_hist[1] && !m_hist[2];
  endfunction

  function automatic logic timer_expire();
`ifdef THREAD_CONTROL_WAKE_TIMER_EN
    return m_timer == 32'd1 && !wr(32'h14);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] reg_val();
    if (hit(32'h08)) return {{(32-T){1'b0}}, m_en};
    if (hit(32'h0C)) return {{(32-T){1'b0}}, m_tgt};
    if (hit(32'h10)) return {30'd0, m_pend};
`ifdef THREAD_CONTROL_WAKE_TIMER_EN
    if (hit(32'h14)) return m_timer;
`endif
    return 32'd0;
  endfunction

  function automatic logic [T-1:0] next_en();
    logic [T-1:0] res, hlt;
    res = wr(32'h00) ? io_write_data[T-1:0] : '0;
    hlt = wr(32'h04) ? io_write_data[T-1:0] : '0;
    return ((m_en | res) & ~hlt) | ((ext_wake() || timer_expire()) ? m_tgt : '0);
  endfunction

  function automatic logic [31:0] next_timer();
`ifdef THREAD_CONTROL_WAKE_TIMER_EN
    if (wr(32'h14)) return io_write_data;
    return (m_timer != 0) ? m_timer - 1 : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en <= 1; m_tgt <= 1; m_pend <= 0; m_rd <= 0; m_timer <= 0; m_hist <= 0;
    end else begin
      m_rd    <= io_read_en ? reg_val() : m_rd;
      m_en    <= next_en();
      m_tgt   <= wr(32'h0C) ? io_write_data[T-1:0] : m_tgt;
      m_pend  <= (m_pend & ~(wr(32'h10) ? io_write_data[1:0] : 2'b00))
                 | {timer_expire(), ext_wake()};
      m_timer <= next_timer();
      m_hist  <= {m_hist[1:0], interrupt_req};
    end
  end

  // Called at a falling edge; strobe covers exactly the next rising edge.
  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    io_write_en = 1'b1; io_address = addr; io_write_data = data;
    @(negedge clk);
    io_write_en = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
    io_read_en = 1'b1; io_address = addr;
    @(negedge clk);
    io_read_en = 1'b0;
    data = io_read_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (thread_enable !== 4'b0001 || processor_halt !== 1'b0 ||
        interrupt_pending !== 2'b00 || io_read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: en=%h halt=%b pend=%b rd=%h, want 1/0/0/0",
               thread_enable, processor_halt, interrupt_pending, io_read_data);
    end
    reset = 1'b0;
    @(negedge clk);
    io_read(BASE + 32'h08, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL reset_read_enable: got %h want 1", d);
    end
  endtask

  task automatic test_resume_halt();
    logic [31:0] d;
    io_write(BASE, 32'h6);
    checks++;
    if (thread_enable !== 4'h7) begin
      errors++; $display("FAIL resume: got %h want 7", thread_enable);
    end
    io_write(BASE + 32'h04, 32'h1);
    checks++;
    if (thread_enable !== 4'h6) begin
      errors++; $display("FAIL halt: got %h want 6", thread_enable);
    end
    io_write(BASE, 32'hFFFF_FFF0);
    checks++;
    if (thread_enable !== 4'h6) begin
      errors++; $display("FAIL resume_high_bits: got %h want 6", thread_enable);
    end
    io_read(32'h7C, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: got %h want 0", d);
    end
  endtask

  task automatic test_interrupt();
    io_write(BASE + 32'h0C, 32'h5);
    io_write(BASE + 32'h04, 32'hF);
    checks++;
    if (processor_halt !== 1'b1 || thread_enable !== 4'h0) begin
      errors++; $display("FAIL halt_all: halt=%b en=%h want 1/0", processor_halt, thread_enable);
    end
    interrupt_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (thread_enable !== 4'h0) begin
      errors++; $display("FAIL wake_early: en=%h want 0 after 2 clocks", thread_enable);
    end
    @(negedge clk);
    checks++;
    if (thread_enable !== 4'h5 || interrupt_pending !== 2'b01 || processor_halt !== 1'b0) begin
      errors++;
      $display("FAIL wake_latency: en=%h pend=%b halt=%b want 5/01/0",
               thread_enable, interrupt_pending, processor_halt);
    end
    io_write(BASE + 32'h10, 32'h1);
    checks++;
    if (interrupt_pending !== 2'b00) begin
      errors++; $display("FAIL pending_ack: got %b want 00", interrupt_pending);
    end
    interrupt_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wake_vs_halt();
    io_write(BASE + 32'h0C, 32'h4);
    interrupt_req = 1'b1;
    repeat (2) @(negedge clk);
    io_write(BASE + 32'h04, 32'h4);
    checks++;
    if (thread_enable[2] !== 1'b1 || thread_enable !== m_en) begin
      errors++; $display("FAIL wake_beats_halt: en=%h want %h (bit2 set)", thread_enable, m_en);
    end
    interrupt_req = 1'b0;
    repeat (4) @(negedge clk);
    interrupt_req = 1'b1;
    repeat (2) @(negedge clk);
    io_write(BASE + 32'h10, 32'h1);
    checks++;
    if (interrupt_pending[0] !== 1'b1) begin
      errors++; $display("FAIL set_beats_ack: pend=%b want bit0=1", interrupt_pending);
    end
    interrupt_req = 1'b0;
    io_write(BASE + 32'h10, 32'h3);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_high();
    int wakes = 0;
    io_write(BASE + 32'h0C, 32'h2);
    io_write(BASE + 32'h04, 32'h2);
    interrupt_req = 1'b1;
    for (int unsigned i = 0; i < 24; i++) begin
      io_write(BASE + 32'h04, 32'h2);
      if (thread_enable[1]) wakes++;
      checks++;
      if (thread_enable !== m_en) begin
        errors++; $display("FAIL hold_cycle%0d: en=%h want %h", i, thread_enable, m_en);
      end
    end
    checks++;
    if (wakes != 1) begin
      errors++; $display("FAIL hold_single_wake: wakes=%0d want 1", wakes);
    end
    interrupt_req = 1'b0;
    io_write(BASE + 32'h10, 32'h3);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timer();
    logic [31:0] d;
`ifdef THREAD_CONTROL_WAKE_TIMER_EN
    io_write(BASE + 32'h0C, 32'h2);
    io_write(BASE + 32'h04, 32'h2);
    io_write(BASE + 32'h10, 32'h3);
    io_write(BASE + 32'h14, 32'd5);
    repeat (4) @(negedge clk);
    checks++;
    if (thread_enable[1] !== 1'b0) begin
      errors++; $display("FAIL timer_early: en=%h want bit1=0", thread_enable);
    end
    @(negedge clk);
    checks++;
    if (thread_enable[1] !== 1'b1 || interrupt_pending !== 2'b10) begin
      errors++; $display("FAIL timer_wake: en=%h pend=%b want bit1=1/10", thread_enable, interrupt_pending);
    end
    io_write(BASE + 32'h04, 32'h2);
    io_write(BASE + 32'h10, 32'h3);
    io_write(BASE + 32'h14, 32'd3);
    repeat (2) @(negedge clk);
    io_write(BASE + 32'h14, 32'd7);
    checks++;
    if (thread_enable[1] !== 1'b0 || interrupt_pending[1] !== 1'b0) begin
      errors++; $display("FAIL timer_reload_on_expiry: en=%h pend=%b want bit1=0", thread_enable, interrupt_pending);
    end
    io_read(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd7) begin
      errors++; $display("FAIL timer_read: got %0d want 7", d);
    end
    io_write(BASE + 32'h14, 32'd0);
    repeat (10) @(negedge clk);
    checks++;
    if (thread_enable[1] !== 1'b0 || interrupt_pending !== 2'b00) begin
      errors++; $display("FAIL timer_cancel: en=%h pend=%b want bit1=0/00", thread_enable, interrupt_pending);
    end
`else
    io_write(BASE + 32'h14, 32'd5);
    io_read(BASE + 32'h14, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL timer_unmapped_read: got %h want 0", d);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (interrupt_pending !== 2'b00) begin
      errors++; $display("FAIL timer_absent_pending: got %b want 00", interrupt_pending);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    io_write(BASE, 32'hF);
    io_write(BASE + 32'h0C, 32'hA);
    io_read(BASE + 32'h08, d);
    interrupt_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (thread_enable !== 4'h1 || interrupt_pending !== 2'b00 ||
        io_read_data !== 32'd0 || processor_halt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%h pend=%b rd=%h want 1/00/0", thread_enable, interrupt_pending, io_read_data);
    end
    interrupt_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    io_read(BASE + 32'h0C, d);
    checks++;
    if (d !== 32'h1 || thread_enable !== 4'h1) begin
      errors++; $display("FAIL post_reset_target: tgt=%h en=%h want 1/1", d, thread_enable);
    end
  endtask

  task automatic test_random();
    logic [31:0] offs [8];
    logic [31:0] a, dat;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) interrupt_req = ~interrupt_req;
      a = BASE + offs[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) a = 32'h7C;
      dat = (a == BASE + 32'h14) ? 32'($urandom_range(0, 9)) : $urandom;
      io_address = a; io_write_data = dat;
      io_write_en = ($urandom_range(0, 2) == 0);
      io_read_en  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      io_write_en = 1'b0; io_read_en = 1'b0;
      checks++;
      if (thread_enable !== m_en || processor_halt !== (m_en == '0) ||
          interrupt_pending !== m_pend || io_read_data !== m_rd) begin
        errors++;
        $display("FAIL random_cycle%0d: en=%h halt=%b pend=%b rd=%h, want en=%h halt=%b pend=%b rd=%h",
                 i, thread_enable, processor_halt, interrupt_pending, io_read_data,
                 m_en, (m_en == '0), m_pend, m_rd);
      end
    end
    interrupt_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_resume_halt();
    test_interrupt();
    test_wake_vs_halt();
    test_hold_high();
    test_timer();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
